// File: rtl/operand_regfile.sv
// operand_regfile: two-read / one-write operand register file, x0 reads as zero, with a clear sweep.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to a matching read port while idle.
//
// state | meaning
// IDLE  | normal operation: writes accepted, clr_req starts a sweep
// CLEAR | zero entry[cnt] each cycle for cnt = 1..NREG-1; writes and clr_req dropped
module operand_regfile #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            clr_req,
  output logic            busy,
  output logic            clr_done
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic            wr_hit, wr_en, sweep_last;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sweep_last = (cnt_q == AW'(NREG - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end
      end
      CLEAR: begin
        if (sweep_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    busy     = (state_q == CLEAR);
    clr_done = (state_q == CLEAR) && sweep_last;
  end

  // Only indices 1..NREG-1 are backed by storage; everything else drops writes and reads zero.
  always_comb begin
    wr_hit = 1'b0;
    for (int i = 1; i < NREG; i++)
      if (waddr == AW'(i)) wr_hit = 1'b1;
  end

  assign wr_en = wen && wr_hit && (state_q == IDLE);

  always_comb begin
    rs1_d = '0;
    rs2_d = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs1_addr == AW'(i)) rs1_d = regs_q[i];
      if (rs2_addr == AW'(i)) rs2_d = regs_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (waddr == rs1_addr)) rs1_d = wdata;
    if (wr_en && (waddr == rs2_addr)) rs2_d = wdata;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if ((state_q == CLEAR) && (cnt_q == AW'(i)))
          regs_q[i] <= '0;
        else if (wr_en && (waddr == AW'(i)))
          regs_q[i] <= wdata;
      end
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;

endmodule

// File: tb/tb_operand_regfile.sv
// tb_operand_regfile: randomized + directed bench for operand_regfile against an array model.
// Honours REGFILE_BYPASS_EN the same way as the design build.
module tb_operand_regfile;

  localparam int NREG = 32;

  logic        clk = 1'b0;
  logic        rstn, wen, clr_req;
  logic [4:0]  waddr, rs1_addr, rs2_addr;
  logic [31:0] wdata, rs1_data, rs2_data;
  logic        busy, clr_done;

  logic        s_rstn, s_wen, s_clr;
  logic [2:0]  s_waddr, s_rs1, s_rs2;
  logic [15:0] s_wdata, s8_rd1, s8_rd2;
  logic [7:0]  s6_rd1, s6_rd2;
  logic        s8_busy, s8_done, s6_busy, s6_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [NREG];
  logic [31:0] exp_rs1, exp_rs2;
  int          sweep_pos;

  always #5 clk = ~clk;

  operand_regfile u_dut (
    .CLK(clk), .RSTN(rstn), .wen(wen), .waddr(waddr), .wdata(wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  operand_regfile #(.XLEN(16), .NREG(8)) u_small8 (
    .CLK(clk), .RSTN(s_rstn), .wen(s_wen), .waddr(s_waddr), .wdata(s_wdata),
    .rs1_addr(s_rs1), .rs2_addr(s_rs2), .rs1_data(s8_rd1), .rs2_data(s8_rd2),
    .clr_req(s_clr), .busy(s8_busy), .clr_done(s8_done)
  );

  operand_regfile #(.XLEN(8), .NREG(6)) u_small6 (
    .CLK(clk), .RSTN(s_rstn), .wen(s_wen), .waddr(s_waddr), .wdata(s_wdata[7:0]),
    .rs1_addr(s_rs1), .rs2_addr(s_rs2), .rs1_data(s6_rd1), .rs2_data(s6_rd2),
    .clr_req(s_clr), .busy(s6_busy), .clr_done(s6_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge: checks the outputs of the last rising edge,
  // applies one cycle of stimulus, advances the model across the next rising edge.
  task automatic drive(input logic rn, input logic w, input int wa, input logic [31:0] wd,
                       input int a1, input int a2, input logic cr);
    check_eq("rs1_data", rs1_data, exp_rs1);
    check_eq("rs2_data", rs2_data, exp_rs2);
    check_eq("busy", {31'b0, busy}, {31'b0, sweep_pos != 0});
    check_eq("clr_done", {31'b0, clr_done}, {31'b0, sweep_pos == NREG - 1});
    rstn = rn; wen = w; waddr = 5'(wa); wdata = wd;
    rs1_addr = 5'(a1); rs2_addr = 5'(a2); clr_req = cr;
    if (!rn) begin
      foreach (mem[i]) mem[i] = '0;
      exp_rs1 = '0; exp_rs2 = '0; sweep_pos = 0;
    end else begin
      exp_rs1 = mem[a1];
      exp_rs2 = mem[a2];
`ifdef REGFILE_BYPASS_EN
      if (w && sweep_pos == 0 && wa != 0 && wa == a1) exp_rs1 = wd;
      if (w && sweep_pos == 0 && wa != 0 && wa == a2) exp_rs2 = wd;
`endif
      if (sweep_pos != 0) begin
        mem[sweep_pos] = '0;
        sweep_pos = (sweep_pos == NREG - 1) ? 0 : sweep_pos + 1;
      end else begin
        if (w && wa != 0) mem[wa] = wd;
        if (cr) sweep_pos = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, done_at, a1;
    rstn = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; rs1_addr = '0; rs2_addr = '0; clr_req = 1'b0;
    s_rstn = 1'b0; s_wen = 1'b0; s_waddr = '0; s_wdata = '0; s_rs1 = '0; s_rs2 = '0; s_clr = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    exp_rs1 = '0; exp_rs2 = '0; sweep_pos = 0;
    repeat (2) @(negedge clk);

    // First write straight out of reset must land.
    drive(1'b1, 1'b1, 5, 32'hDEADBEEF, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 32'h0, 5, 0, 1'b0);
    check_eq("x5_read", rs1_data, 32'hDEADBEEF);

    drive(1'b1, 1'b1, 0, 32'h12345678, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0);
    check_eq("x0_rs1", rs1_data, 32'h0);
    check_eq("x0_rs2", rs2_data, 32'h0);

    drive(1'b1, 1'b1, 7, 32'h1, 0, 0, 1'b0);
    drive(1'b1, 1'b1, 7, 32'hA5A5A5A5, 0, 7, 1'b0);
`ifdef REGFILE_BYPASS_EN
    check_eq("bypass_x7", rs2_data, 32'hA5A5A5A5);
`else
    check_eq("bypass_x7", rs2_data, 32'h00000001);
`endif
    idle_cycle();

    // Full sweep with a dropped write to x3 in the middle.
    for (int i = 1; i < NREG; i++) drive(1'b1, 1'b1, i, 32'(i), 0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 32'h0, 3, 4, 1'b1);
    n = 0; done_at = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (clr_done === 1'b1) done_at = n;
      drive(1'b1, n == 5, 3, 32'hFFFF, n % 32, 3, 1'b0);
    end
    check_eq("sweep_len", 32'(n), 32'd31);
    check_eq("done_cycle", 32'(done_at), 32'd31);
    for (int i = 0; i < NREG; i++) drive(1'b1, 1'b0, 0, 32'h0, i, NREG - 1 - i, 1'b0);

    // Reset in sweep cycle 10 aborts without a done pulse.
    for (int i = 1; i < NREG; i++) drive(1'b1, 1'b1, i, 32'(i) ^ 32'hF0F0_0000, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b1);
    repeat (9) idle_cycle();
    drive(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b0);
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    check_eq("abort_done", {31'b0, clr_done}, 32'd0);
    for (int i = 0; i < NREG; i++) drive(1'b1, 1'b0, 0, 32'h0, i, i, 1'b0);

    // Randomized traffic including sweeps, collisions and occasional resets.
    for (int k = 0; k < 600; k++) begin
      int wa;
      wa = $urandom_range(0, NREG - 1);
      a1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NREG - 1);
      drive($urandom_range(0, 149) != 0, 1'($urandom_range(0, 1)), wa, $urandom,
            a1, ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NREG - 1),
            $urandom_range(0, 39) == 0);
    end
    idle_cycle();
    idle_cycle();

    // Small configurations: NREG=8/XLEN=16 and NREG=6/XLEN=8 (index 7 out of range).
    s_rstn = 1'b1; s_wen = 1'b1; s_waddr = 3'd7; s_wdata = 16'hBEEF;
    @(negedge clk);
    s_waddr = 3'd5; s_wdata = 16'h1266;
    @(negedge clk);
    s_wen = 1'b0; s_rs1 = 3'd7; s_rs2 = 3'd5;
    @(negedge clk);
    check_eq("n8_x7", {16'b0, s8_rd1}, 32'h0000BEEF);
    check_eq("n8_x5", {16'b0, s8_rd2}, 32'h00001266);
    check_eq("n6_x7_oor", {24'b0, s6_rd1}, 32'h0);
    check_eq("n6_x5", {24'b0, s6_rd2}, 32'h00000066);
    s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    begin
      int b8, b6, d8, d6;
      b8 = 0; b6 = 0; d8 = 0; d6 = 0;
      for (int k = 0; k < 12; k++) begin
        if (s8_busy === 1'b1) b8++;
        if (s6_busy === 1'b1) b6++;
        if (s8_done === 1'b1) d8++;
        if (s6_done === 1'b1) d6++;
        @(negedge clk);
      end
      check_eq("n8_sweep_len", 32'(b8), 32'd7);
      check_eq("n6_sweep_len", 32'(b6), 32'd5);
      check_eq("n8_done_cnt", 32'(d8), 32'd1);
      check_eq("n6_done_cnt", 32'(d6), 32'd1);
    end
    check_eq("n8_x7_cleared", {16'b0, s8_rd1}, 32'h0);
    check_eq("n8_x5_cleared", {16'b0, s8_rd2}, 32'h0);
    check_eq("n6_x5_cleared", {24'b0, s6_rd2}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_regfile.md
OPERAND_REGFILE -- requirements
Module: operand_regfile

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the register data width in bits.
REQ-002 The block SHALL take parameter NREG, default 32, as the register count, legal range 2..32.
REQ-003 The block SHALL derive the address width AW as clog2(NREG); AW SHALL NOT be overridable.
REQ-004 CLK  input  1  is the single clock; every register SHALL update on its rising edge only.
REQ-005 RSTN  input  1  is the reset: one clock, synchronous and active-low.
REQ-006 wen  input  1  is the write enable.
REQ-007 waddr  input  AW  is the write register index.
REQ-008 wdata  input  XLEN  is the write data.
REQ-009 rs1_addr  input  AW  is the read port 1 index.
REQ-010 rs2_addr  input  AW  is the read port 2 index.
REQ-011 rs1_data  output  XLEN  is the registered read port 1 data.
REQ-012 rs2_data  output  XLEN  is the registered read port 2 data.
REQ-013 clr_req  input  1  is a single-cycle request to start a clear sweep.
REQ-014 busy  output  1  is high while a clear sweep is in progress.
REQ-015 clr_done  output  1  is a one-cycle pulse on the last sweep cycle.

Function
REQ-016 A write with wen=1 and waddr!=0 SHALL update entry waddr at the next edge.
REQ-017 A write to index 0 SHALL be discarded; entry 0 SHALL always read 0.
REQ-018 Indices >= NREG SHALL be ignored on write and SHALL read 0.
REQ-019 Each read port SHALL have 1-cycle latency: rsN_data at edge k+1 SHALL equal the entry addressed at edge k.
REQ-020 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-021 The FSM SHALL have exactly two states, IDLE and CLEAR.
REQ-022 In IDLE, clr_req=1 SHALL move the FSM to CLEAR and load the sweep counter with 1.
REQ-023 In CLEAR, the block SHALL zero entry[counter] every cycle and increment the counter.
REQ-024 When counter = NREG-1, that entry SHALL be zeroed, clr_done SHALL be 1 for that cycle only, and the FSM SHALL return to IDLE; a sweep therefore lasts NREG-1 cycles.
REQ-025 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-026 In CLEAR, external writes SHALL be dropped and clr_req SHALL be ignored.
REQ-027 In CLEAR, reads SHALL continue to be served from the current array contents.
REQ-028 If wen=1 arrives in the same cycle that IDLE accepts clr_req, the write SHALL be performed and the sweep SHALL then clear that entry.

Reset
REQ-029 While RSTN=0 at an edge, all entries, rs1_data, rs2_data, busy, clr_done and the counter SHALL become 0, and the FSM SHALL become IDLE.
REQ-030 A reset asserted during a sweep SHALL abort the sweep, with no clr_done pulse.
REQ-031 The first write after reset SHALL be accepted at the first edge with RSTN=1.

Configuration
REQ-032 The macro REGFILE_BYPASS_EN SHALL control write-to-read bypass.
REQ-033 With REGFILE_BYPASS_EN defined: if wen=1, waddr=rsN_addr!=0 and the FSM is IDLE, rsN_data SHALL capture wdata in the same edge.
REQ-034 Without REGFILE_BYPASS_EN: under the same conditions, rsN_data SHALL capture the old entry value.

Verification
REQ-035 Write x5=0xDEADBEEF; next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF one cycle later.
REQ-036 Write x0=0x12345678; then rs1_addr=rs2_addr=0 -> both ports return 0x00000000.
REQ-037 Same-cycle wen=1, waddr=7, wdata=0xA5A5A5A5, rs2_addr=7, old x7=0x1 -> rs2_data=0xA5A5A5A5 with REGFILE_BYPASS_EN; 0x00000001 without it.
REQ-038 Fill x1..x31 with the value i; pulse clr_req -> busy=1 for 31 cycles, clr_done on cycle 31, all reads 0; a write to x3 during the sweep is dropped.
REQ-039 Drop RSTN at sweep cycle 10 -> busy=0 and clr_done=0 at the next edge, all entries 0, FSM IDLE.
REQ-040 NREG=8, XLEN=16: write x7=0xBEEF, then read x7 -> 0xBEEF; sweep lasts 7 cycles.
